// File: rtl/selfwrite_cfg_loader.sv
// selfwrite_cfg_loader: streams a header-checked bitstream image from 1-cycle-latency memory into the fabric self-write port.
// Define SELFWRITE_CHECKSUM_EN to require a trailing XOR word after the payload.
module selfwrite_cfg_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1,
  parameter int          STROBE_GAP = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  SelfWriteStrobe,
  output logic [31:0]           SelfWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] words_written
);
  typedef enum logic [3:0] {
    IDLE, RD_SYNC, CHK_SYNC, RD_LEN, CHK_LEN, RD_DATA, STROBE, GAP, RD_CHK, CMP_CHK, DONE, ERROR
  } state_t;
`ifdef SELFWRITE_CHECKSUM_EN
  localparam int     TAIL = 3;
  localparam state_t FIN  = RD_CHK;
`else
  localparam int     TAIL = 2;
  localparam state_t FIN  = DONE;
`endif
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'((1 << ADDR_WIDTH) - TAIL);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ww_q, ww_d, len_q, len_d, wr_next;
  logic [1:0]            err_q, err_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            gap_q, gap_d;
  logic                  idle_st;
`ifdef SELFWRITE_CHECKSUM_EN
  logic [31:0]           xor_q, xor_d;
`endif
  assign idle_st       = state_q inside {IDLE, DONE, ERROR};
  assign wr_next       = ww_q + ADDR_WIDTH'(1);
  assign busy          = !idle_st;
  assign done          = state_q == DONE;
  assign error         = state_q == ERROR;
  assign err_code      = err_q;
  assign words_written = ww_q;
  // Strobe decodes straight from state so it falls the instant RST asserts;
  // the memory holds rdata through STROBE, so the word is stable under it.
  assign SelfWriteStrobe = state_q == STROBE && !abort;
  assign SelfWriteData   = state_q == STROBE ? mem_rdata : data_q;
  always_comb begin
    state_d  = state_q;
    ww_d     = ww_q;
    len_d    = len_q;
    err_d    = err_q;
    data_d   = data_q;
    gap_d    = gap_q;
`ifdef SELFWRITE_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    mem_en   = 1'b0;
    mem_addr = '0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        ww_d    = '0;
        err_d   = abort ? 2'd3 : 2'd0;
        state_d = abort ? ERROR : RD_SYNC;
`ifdef SELFWRITE_CHECKSUM_EN
        xor_d   = '0;
`endif
      end
      RD_SYNC: begin
        mem_en  = 1'b1;
        state_d = CHK_SYNC;
      end
      CHK_SYNC: begin
        state_d = mem_rdata == SYNC_WORD ? RD_LEN : ERROR;
        err_d   = mem_rdata == SYNC_WORD ? err_q : 2'd1;
      end
      RD_LEN: begin
        mem_en   = 1'b1;
        mem_addr = ADDR_WIDTH'(1);
        state_d  = CHK_LEN;
      end
      CHK_LEN: begin
        len_d = mem_rdata[ADDR_WIDTH-1:0];
        if (|mem_rdata[31:ADDR_WIDTH] || mem_rdata[ADDR_WIDTH-1:0] > MAX_N) begin
          state_d = ERROR;
          err_d   = 2'd2;
        end else
          state_d = mem_rdata[ADDR_WIDTH-1:0] == '0 ? DONE : RD_DATA;
      end
      RD_DATA: begin
        mem_en   = 1'b1;
        mem_addr = ww_q + ADDR_WIDTH'(2);
        state_d  = STROBE;
      end
      STROBE: begin
        ww_d    = wr_next;
        data_d  = mem_rdata;
        gap_d   = '0;
        state_d = STROBE_GAP > 0 ? GAP : wr_next == len_q ? FIN : RD_DATA;
`ifdef SELFWRITE_CHECKSUM_EN
        xor_d   = xor_q ^ mem_rdata;
`endif
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == 4'(STROBE_GAP - 1)) state_d = ww_q == len_q ? FIN : RD_DATA;
      end
`ifdef SELFWRITE_CHECKSUM_EN
      RD_CHK: begin
        mem_en   = 1'b1;
        mem_addr = len_q + ADDR_WIDTH'(2);
        state_d  = CMP_CHK;
      end
      CMP_CHK: begin
        state_d = mem_rdata == xor_q ? DONE : ERROR;
        err_d   = mem_rdata == xor_q ? err_q : 2'd3;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Abort suppresses any write still pending in this cycle.
    if (!idle_st && abort) begin
      state_d = ERROR;
      err_d   = 2'd3;
      ww_d    = ww_q;
      data_d  = data_q;
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      ww_q    <= '0;
      len_q   <= '0;
      err_q   <= '0;
      data_q  <= '0;
      gap_q   <= '0;
`ifdef SELFWRITE_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ww_q    <= ww_d;
      len_q   <= len_d;
      err_q   <= err_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
`ifdef SELFWRITE_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
endmodule

// File: tb/tb_selfwrite_cfg_loader.sv
// tb_selfwrite_cfg_loader: directed checks of header validation, pacing, boundaries, abort and async reset.
module tb_selfwrite_cfg_loader;
  logic        CLK = 0, RST = 1, start = 0, abort = 0;
  logic        mem_en, SelfWriteStrobe, busy, done, error;
  logic [11:0] mem_addr, words_written;
  logic [31:0] mem_rdata = 0, SelfWriteData;
  logic [1:0]  err_code;
  logic [31:0] mem [0:4095];
  int          cyc = 0, total = 0, bad = 0, ns = 0, nm = 0, dbl = 0, b = 0, bm = 0, t0 = 0;
  logic        ps = 0;
  int          st [0:16383];
  logic [31:0] sd [0:16383];
  logic [11:0] ma [0:16383];
  logic [31:0] x;

  selfwrite_cfg_loader dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .SelfWriteStrobe(SelfWriteStrobe), .SelfWriteData(SelfWriteData),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .words_written(words_written)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (mem_en) mem_rdata <= mem[mem_addr];

  always @(negedge CLK) begin
    if (SelfWriteStrobe) begin
      st[ns % 16384] = cyc;
      sd[ns % 16384] = SelfWriteData;
      ns++;
    end
    if (SelfWriteStrobe && ps) dbl++;
    ps = SelfWriteStrobe;
    if (mem_en) begin
      ma[nm % 16384] = mem_addr;
      nm++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic go();
    b  = ns;
    bm = nm;
    start = 1;
    step();
    start = 0;
    t0 = cyc;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !(done || error); i++) step();
    if (!(done || error)) chk("timeout", 0, 1);
  endtask

  task automatic image(input logic [31:0] n);
    x = 0;
    mem[0] = 32'hFAB0_FAB1;
    mem[1] = n;
    for (int i = 0; i < n && i < 4094; i++) begin
      mem[i + 2] = 32'h1000_0000 + i * 32'h0101_0003;
      x ^= mem[i + 2];
    end
    if (n < 4094) mem[n + 2] = x;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_flags", {busy, done, error, err_code, SelfWriteStrobe, mem_en}, 0);
    chk("rst_ww", words_written, 0);
    chk("rst_data", SelfWriteData, 0);
    RST = 0;
    step();
    // start and abort together in IDLE
    bm = nm;
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    step();
    chk("sa_error", error, 1);
    chk("sa_code", err_code, 3);
    chk("sa_reads", nm - bm, 0);
    // normal load
    mem[0] = 32'hFAB0_FAB1;
    mem[1] = 3;
    mem[2] = 32'h1111_1111;
    mem[3] = 32'h2222_2222;
    mem[4] = 32'h3333_3333;
    mem[5] = 32'h0000_0000;
    go();
    wait_end(100);
    chk("n_cnt", ns - b, 3);
    chk("n_d0", sd[b], 32'h1111_1111);
    chk("n_d1", sd[b + 1], 32'h2222_2222);
    chk("n_d2", sd[b + 2], 32'h3333_3333);
    chk("n_first", st[b] - t0, 5);
    chk("n_gap1", st[b + 1] - st[b], 3);
    chk("n_gap2", st[b + 2] - st[b + 1], 3);
    chk("n_done", {busy, done, error}, 3'b010);
    chk("n_ww", words_written, 3);
    chk("n_hold", SelfWriteData, 32'h3333_3333);
    chk("n_single", dbl, 0);
    // bad sync
    mem[0] = 32'hDEAD_BEEF;
    go();
    wait_end(100);
    chk("bs_error", error, 1);
    chk("bs_code", err_code, 1);
    chk("bs_strobes", ns - b, 0);
    chk("bs_reads", nm - bm, 1);
    // N = 0
    image(0);
    go();
    wait_end(100);
    chk("n0_done", {done, error}, 2'b10);
    chk("n0_strobes", ns - b, 0);
    chk("n0_ww", words_written, 0);
    // upper length bits set
    mem[1] = 32'h0001_0000;
    go();
    wait_end(100);
    chk("big_error", error, 1);
    chk("big_code", err_code, 2);
    // N = 4094
    image(4094);
    go();
`ifdef SELFWRITE_CHECKSUM_EN
    wait_end(100);
    chk("max_error", error, 1);
    chk("max_code", err_code, 2);
`else
    wait_end(13000);
    chk("max_done", done, 1);
    chk("max_cnt", ns - b, 4094);
    chk("max_addr", ma[(nm - 1) % 16384], 4095);
    chk("max_ww", words_written, 4094);
    chk("max_data", SelfWriteData, mem[4095]);
`endif
    // abort after the 2nd strobe, then restart
    image(10);
    go();
    for (int i = 0; i < 100 && ns - b < 2; i++) step();
    step();
    abort = 1;
    step();
    abort = 0;
    repeat (20) step();
    chk("ab_error", error, 1);
    chk("ab_code", err_code, 3);
    chk("ab_ww", words_written, 2);
    chk("ab_strobes", ns - b, 2);
    go();
    wait_end(200);
    chk("ab_addr0", ma[bm % 16384], 0);
    chk("ab_redo", ns - b, 10);
    chk("ab_ww2", words_written, 10);
    // async reset while strobe is high
    image(3);
    go();
    for (int i = 0; i < 100 && ns == b; i++) step();
    chk("rs_hi", SelfWriteStrobe, 1);
    RST = 1;
    #1;
    chk("rs_strobe", SelfWriteStrobe, 0);
    chk("rs_flags", {busy, done, error, err_code, mem_en}, 0);
    chk("rs_ww", words_written, 0);
    chk("rs_data", SelfWriteData, 0);
    step();
    RST = 0;
    step();
    go();
    wait_end(100);
    chk("rs_cnt", ns - b, 3);
    chk("rs_last", sd[b + 2], mem[4]);
    chk("rs_done", done, 1);
`ifdef SELFWRITE_CHECKSUM_EN
    mem[1] = 3;
    mem[2] = 1;
    mem[3] = 2;
    mem[4] = 4;
    mem[5] = 7;
    go();
    wait_end(100);
    chk("ck_done", done, 1);
    chk("ck_cnt", ns - b, 3);
    mem[5] = 6;
    go();
    wait_end(100);
    chk("ck_error", error, 1);
    chk("ck_code", err_code, 3);
    chk("ck_bad_cnt", ns - b, 3);
`endif
    chk("single", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/selfwrite_cfg_loader.md
Name: selfwrite_cfg_loader

Overview:
- Sequencer for the fabric's self-write configuration port (SelfWriteStrobe/SelfWriteData) on eFPGA_top.
- Streams a stored bitstream image from a synchronous read memory (ROM/BRAM, 1-cycle read latency) into the fabric.
- Validates the image header, paces strobes, and reports done/error.
- Sits beside eFPGA_top in the emulation/board top, replacing tie-offs of the self-write port.

Parameters:
- ADDR_WIDTH, 12, image memory word-address width.
- SYNC_WORD, 32'hFAB0_FAB1, required value of image word 0.
- STROBE_GAP, 1, idle cycles inserted after each strobe (0..15).

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin loading; sampled only in IDLE, DONE or ERROR.
- abort  input  1  stop loading at the next cycle boundary and go to ERROR.
- mem_en  output  1  read enable to image memory.
- mem_addr  output  ADDR_WIDTH  word address to image memory.
- mem_rdata  input  32  read data, valid the cycle after mem_en.
- SelfWriteStrobe  output  1  one-cycle write pulse to fabric.
- SelfWriteData  output  32  configuration word; stable while strobe is high.
- busy  output  1  high from accepted start until DONE or ERROR.
- done  output  1  level, high in DONE.
- error  output  1  level, high in ERROR.
- err_code  output  2  0 none, 1 bad sync, 2 bad length, 3 abort or checksum.
- words_written  output  ADDR_WIDTH  count of strobes issued in the current load.

Behaviour:
- Reset (async, immediate) clears all outputs and registers to 0; state IDLE.
  - SelfWriteStrobe must drop in the same cycle RST asserts.
- Image format: word0 = SYNC_WORD; word1 = payload length N (low ADDR_WIDTH bits used, upper bits must be 0); words 2..N+1 = payload.
- Memory protocol: mem_en is a single-cycle pulse with mem_addr. mem_rdata is captured exactly one cycle later. Only one read is outstanding at a time.
- State machine:
  - IDLE: on start, clear words_written and err_code, set busy, go to RD_SYNC.
  - RD_SYNC: mem_en=1, addr 0, go to CHK_SYNC.
  - CHK_SYNC: if rdata==SYNC_WORD go to RD_LEN; else ERROR, code 1.
  - RD_LEN: mem_en=1, addr 1, go to CHK_LEN.
  - CHK_LEN: if upper bits are nonzero, or N > 2^ADDR_WIDTH-2, go to ERROR with code 2. If N==0, go to DONE with no strobe. Otherwise latch N and go to RD_DATA.
  - RD_DATA: mem_en=1, addr = 2+words_written, go to STROBE.
  - STROBE: SelfWriteData <= rdata, SelfWriteStrobe=1 for this cycle only, words_written++.
    - Go to GAP if STROBE_GAP>0.
    - Otherwise go to RD_DATA, or to DONE/CHK after the last word.
  - GAP: count STROBE_GAP cycles, then go to RD_DATA, or to DONE/CHK after the last word.
  - DONE / ERROR: busy=0, hold flags, await start.
- Throughput: with STROBE_GAP=0, one strobe every 2 cycles.
- First strobe occurs exactly 5 cycles after the start-accept edge.
- SelfWriteData holds the last written word between strobes and in DONE. It clears only on reset.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins, go to ERROR with code 3 and no reads.
- abort while busy: takes effect next edge; no strobe in that cycle or after.
- words_written saturation cannot occur: length is bounded in CHK_LEN.
- Address never wraps; the maximum address is 2^ADDR_WIDTH-1.

Optional Feature:
- Macro: SELFWRITE_CHECKSUM_EN.
- Defined:
  - Image carries one trailing word at addr N+2.
  - The loader keeps a 32-bit XOR of all payload words.
  - After the last strobe it reads the trailing word (states RD_CHK, CMP_CHK).
  - Match goes to DONE; mismatch goes to ERROR with code 3.
  - The trailing word is never strobed to the fabric.
  - Length bound becomes N <= 2^ADDR_WIDTH-3.
- Undefined: no trailing read. DONE follows the last strobe/gap directly. No XOR register is present.

Test Plan:
- Normal load: image {FAB0FAB1, 3, 11111111, 22222222, 33333333}, STROBE_GAP=1, pulse start. Required: 3 single-cycle strobes carrying the data in order; first strobe 5 cycles after start; strobes 3 cycles apart; done=1, words_written=3, busy=0.
- Bad sync: word0=DEADBEEF. Required: error=1, err_code=1, zero strobes, exactly one mem_en pulse.
- Length boundaries:
  - N=0: done, no strobes.
  - N=32'h0001_0000: error, code 2.
  - N=4094 (ADDR_WIDTH=12): 4094 strobes; last read addr 4095.
- Abort after the 2nd strobe of N=10: no further strobes; error, code 3; words_written=2. A new start then restarts from addr 0.
- Reset mid-STROBE: RST asserted asynchronously between edges while the strobe is high. Required: strobe drops immediately; all outputs 0; a start after release performs a full clean load.
- With SELFWRITE_CHECKSUM_EN:
  - Payload {1,2,4}, trailing 7: done.
  - Trailing 6: error, code 3, after 3 strobes.
